// File: rtl/dmem_ctrl_pkg.sv
// Shared constants, size/state encodings and small helpers for the data-memory controller.
package dmem_ctrl_pkg;

    localparam int ADDR_LEN = 32;
    localparam int REG_LEN  = 32;

    localparam logic [1:0] IO_HI_BITS = 2'b11;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RDW,
        ST_WR,
        ST_DONE
    } state_e;

    // Index of the final byte transferred for a request of the given size.
    function automatic logic [1:0] last_byte_idx(input logic [1:0] size);
        case (size)
            SIZE_B:  return 2'd0;
            SIZE_H:  return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic is_io(input logic [ADDR_LEN-1:0] addr);
        return addr[17:16] == IO_HI_BITS;
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// Combinational lane logic: zero-extended load lane extract and byte-enable merge of store data.
module dmem_lane import dmem_ctrl_pkg::*; (
    input  logic [REG_LEN-1:0] ld_word_i,
    input  logic [REG_LEN-1:0] st_old_i,
    input  logic [REG_LEN-1:0] st_data_i,
    input  logic [1:0]         addr_lo_i,
    input  logic [1:0]         size_i,
    output logic [REG_LEN-1:0] ld_data_o,
    output logic [REG_LEN-1:0] st_word_o
);

    logic [REG_LEN-1:0] mask;
    logic [REG_LEN-1:0] mask_sh;
    logic [REG_LEN-1:0] data_sh;

    always_comb begin
        ld_data_o = ld_word_i;
        mask      = 32'hFFFF_FFFF;
        case (size_i)
            SIZE_B: begin
                ld_data_o = {24'd0, ld_word_i[{addr_lo_i, 3'b000} +: 8]};
                mask      = 32'h0000_00FF;
            end
            SIZE_H: begin
                ld_data_o = {16'd0, ld_word_i[{addr_lo_i[1], 4'b0000} +: 16]};
                mask      = 32'h0000_FFFF;
            end
            default: begin
                ld_data_o = ld_word_i;
                mask      = 32'hFFFF_FFFF;
            end
        endcase
        // Store data arrives in the low lanes and is moved up to its byte offset.
        mask_sh   = mask << {addr_lo_i, 3'b000};
        data_sh   = st_data_i << {addr_lo_i, 3'b000};
        st_word_o = (st_old_i & ~mask_sh) | (data_sh & mask_sh);
    end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data controller: word-cache hits, byte-serial RAM refill/IO reads, write-through stores.
// Define DMEM_CACHE_EN to use the cache; without it every load goes to RAM and nothing is refilled.
module dmem_ctrl import dmem_ctrl_pkg::*; (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic [ADDR_LEN-1:0] req_addr,
    input  logic [REG_LEN-1:0]  req_wdata,
    output logic                req_ready,
    output logic                resp_valid,
    output logic [REG_LEN-1:0]  resp_data,
    output logic [ADDR_LEN-1:0] cache_addr,
    input  logic [REG_LEN-1:0]  cache_data,
    input  logic                cache_hit,
    output logic                cache_replace,
    output logic [REG_LEN-1:0]  cache_wdata,
    output logic [ADDR_LEN-1:0] ram_addr,
    output logic                ram_wr,
    output logic [7:0]          ram_dout,
    input  logic [7:0]          ram_din
);

`ifdef DMEM_CACHE_EN
    localparam logic CacheEn = 1'b1;
`else
    localparam logic CacheEn = 1'b0;
`endif

    state_e              state_q;
    logic                resp_valid_q;
    logic [REG_LEN-1:0]  resp_data_q;
    logic                cache_replace_q;
    logic                ram_wr_q;
    logic [ADDR_LEN-1:0] ram_addr_q;
    logic [7:0]          ram_dout_q;
    logic [ADDR_LEN-1:0] addr_q;
    logic [REG_LEN-1:0]  wdata_q;
    logic [1:0]          size_q;
    logic [REG_LEN-1:0]  word_q;
    logic [1:0]          cnt_q;
    logic [1:0]          last_q;
    logic                io_q;
    logic                hit_q;

    logic                idle;
    logic                req_io;
    logic                req_hit;
    logic [1:0]          cnt_d;
    logic [REG_LEN-1:0]  asm_word_d;
    logic [REG_LEN-1:0]  load_lane;
    logic [REG_LEN-1:0]  merged_word;

    assign idle      = (state_q == ST_IDLE);
    assign req_io    = is_io(req_addr);
    assign req_hit   = CacheEn && cache_hit && !req_io;
    assign cnt_d     = cnt_q + 2'd1;

    assign req_ready     = idle;
    assign resp_valid    = resp_valid_q;
    assign resp_data     = resp_data_q;
    assign cache_addr    = idle ? req_addr : addr_q;
    assign cache_replace = CacheEn & cache_replace_q;
    assign cache_wdata   = (state_q == ST_WR) ? merged_word : asm_word_d;
    assign ram_addr      = ram_addr_q;
    assign ram_wr        = ram_wr_q;
    assign ram_dout      = ram_dout_q;

    // The byte arriving this cycle completes the word at lane cnt_q (used in RDW).
    always_comb begin
        asm_word_d = word_q;
        asm_word_d[{cnt_q, 3'b000} +: 8] = ram_din;
    end

    // IO reads are assembled from lane 0 upward, so their lane select ignores the offset.
    dmem_lane u_lane (
        .ld_word_i (idle ? cache_data : asm_word_d),
        .st_old_i  (cache_data),
        .st_data_i (wdata_q),
        .addr_lo_i ((!idle && io_q) ? 2'b00 : cache_addr[1:0]),
        .size_i    (idle ? req_size : size_q),
        .ld_data_o (load_lane),
        .st_word_o (merged_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            resp_valid_q    <= 1'b0;
            resp_data_q     <= '0;
            cache_replace_q <= 1'b0;
            ram_wr_q        <= 1'b0;
            ram_addr_q      <= '0;
            ram_dout_q      <= '0;
            addr_q          <= '0;
            wdata_q         <= '0;
            size_q          <= SIZE_B;
            word_q          <= '0;
            cnt_q           <= '0;
            last_q          <= '0;
            io_q            <= 1'b0;
            hit_q           <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    resp_valid_q    <= 1'b0;
                    cache_replace_q <= 1'b0;
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        size_q  <= req_size;
                        io_q    <= req_io;
                        hit_q   <= req_hit;
                        cnt_q   <= '0;
                        word_q  <= '0;
                        if (req_we) begin
                            state_q         <= ST_WR;
                            ram_addr_q      <= req_addr;
                            ram_wr_q        <= 1'b1;
                            ram_dout_q      <= req_wdata[7:0];
                            last_q          <= last_byte_idx(req_size);
                            cache_replace_q <= req_hit && (last_byte_idx(req_size) == 2'd0);
                        end else if (req_hit) begin
                            resp_valid_q <= 1'b1;
                            resp_data_q  <= load_lane;
                        end else begin
                            state_q    <= ST_RD;
                            ram_addr_q <= req_io ? req_addr : {req_addr[ADDR_LEN-1:2], 2'b00};
                            last_q     <= req_io ? last_byte_idx(req_size) : 2'd3;
                        end
                    end
                end
                ST_RD: begin
                    if (cnt_q != 2'd0) begin
                        word_q[{cnt_q - 2'd1, 3'b000} +: 8] <= ram_din;
                    end
                    if (cnt_q == last_q) begin
                        state_q         <= ST_RDW;
                        cache_replace_q <= CacheEn && !io_q;
                    end else begin
                        cnt_q      <= cnt_d;
                        ram_addr_q <= ram_addr_q + 32'd1;
                    end
                end
                ST_RDW: begin
                    word_q          <= asm_word_d;
                    resp_data_q     <= load_lane;
                    resp_valid_q    <= 1'b1;
                    cache_replace_q <= 1'b0;
                    state_q         <= ST_DONE;
                end
                ST_WR: begin
                    if (cnt_q == last_q) begin
                        ram_wr_q        <= 1'b0;
                        cache_replace_q <= 1'b0;
                        resp_valid_q    <= 1'b1;
                        state_q         <= ST_DONE;
                    end else begin
                        cnt_q           <= cnt_d;
                        ram_addr_q      <= ram_addr_q + 32'd1;
                        ram_dout_q      <= wdata_q[{cnt_d, 3'b000} +: 8];
                        cache_replace_q <= hit_q && (cnt_d == last_q);
                    end
                end
                ST_DONE: begin
                    resp_valid_q <= 1'b0;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl with a byte RAM model (1-cycle read latency) and a 16-line cache model.
module tb_dmem_ctrl;

`ifdef DMEM_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [31:0] cache_addr;
    logic [31:0] cache_data;
    logic        cache_hit;
    logic        cache_replace;
    logic [31:0] cache_wdata;
    logic [31:0] ram_addr;
    logic        ram_wr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din = 8'd0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accCyc = 0;
    int replCount = 0;
    int addrChanges = 0;
    logic [31:0] lastRamAddr = 32'd0;

    logic [7:0]  mem [0:262143];
    logic [31:0] cData [0:15];
    logic [25:0] cTag [0:15];
    logic [15:0] cValid = '0;

    logic [31:0] expDataQ[$];
    int          expLatQ[$];
    bit          expChkQ[$];
    string       tagQ[$];
    logic [31:0] wrAddrQ[$];
    logic [7:0]  wrDataQ[$];

    dmem_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_we        (req_we),
        .req_size      (req_size),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_ready     (req_ready),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .cache_addr    (cache_addr),
        .cache_data    (cache_data),
        .cache_hit     (cache_hit),
        .cache_replace (cache_replace),
        .cache_wdata   (cache_wdata),
        .ram_addr      (ram_addr),
        .ram_wr        (ram_wr),
        .ram_dout      (ram_dout),
        .ram_din       (ram_din)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: registered read gives data one cycle after the address.
    always @(posedge clk) begin
        if (ram_wr) mem[ram_addr[17:0]] <= ram_dout;
        ram_din <= mem[ram_addr[17:0]];
    end

    // Direct-mapped cache model: lookup is combinational, refill on cache_replace.
    assign cache_hit  = cValid[cache_addr[5:2]] && (cTag[cache_addr[5:2]] == cache_addr[31:6]);
    assign cache_data = cData[cache_addr[5:2]];

    always @(posedge clk) begin
        if (cache_replace) begin
            cData[cache_addr[5:2]]  <= cache_wdata;
            cTag[cache_addr[5:2]]   <= cache_addr[31:6];
            cValid[cache_addr[5:2]] <= 1'b1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit modelHit(input logic [31:0] a);
        return cValid[a[5:2]] && (cTag[a[5:2]] == a[31:6]);
    endfunction

    // Monitor: scoreboard pops on resp_valid, plus activity counters per transaction.
    always @(negedge clk) begin
        if (!rst) begin
            if (cache_replace) begin
                replCount++;
                checkOutput("replace_vs_ready", {31'd0, req_ready}, 32'd0);
            end
            if (ram_addr != lastRamAddr) begin
                addrChanges++;
                lastRamAddr = ram_addr;
            end
            if (ram_wr) begin
                wrAddrQ.push_back(ram_addr);
                wrDataQ.push_back(ram_dout);
            end
            if (resp_valid) begin
                if (expDataQ.size() == 0) begin
                    checkOutput("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    logic [31:0] eData;
                    int eLat;
                    bit eChk;
                    string eTag;
                    eData = expDataQ.pop_front();
                    eLat  = expLatQ.pop_front();
                    eChk  = expChkQ.pop_front();
                    eTag  = tagQ.pop_front();
                    if (eChk) checkOutput({eTag, "_data"}, resp_data, eData);
                    checkOutput({eTag, "_lat"}, cyc - accCyc + 1, eLat);
                end
            end
        end
    end

    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic [31:0] addr,
                                 input logic [31:0] wdata, input string tag, input bit track);
        int nb;
        int lat;
        bit io;
        logic [31:0] expWord;
        logic [17:0] a;
        nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        io = (addr[17:16] == 2'b11);
        expWord = 32'd0;
        for (int k = 0; k < nb; k++) begin
            a = addr[17:0] + 18'(k);
            expWord = expWord | (32'(mem[a]) << (8 * k));
        end
        if (we) lat = nb + 1;
        else if (io) lat = nb + 2;
        else if (CACHE_EN && modelHit(addr)) lat = 1;
        else lat = 6;

        @(negedge clk);
        checkOutput({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wdata;
        if (track) begin
            expDataQ.push_back(expWord);
            expLatQ.push_back(lat);
            expChkQ.push_back(!we);
            tagQ.push_back(tag);
        end
        @(posedge clk);
        #1;
        accCyc = cyc;
        replCount = 0;
        addrChanges = 0;
        wrAddrQ.delete();
        wrDataQ.delete();
        req_valid = 1'b0;
        if (track) begin
            for (int i = 0; i < 30 && expDataQ.size() != 0; i++) @(negedge clk);
            if (expDataQ.size() != 0) begin
                checkOutput({tag, "_timeout"}, 32'd1, 32'd0);
                expDataQ.delete();
                expLatQ.delete();
                expChkQ.delete();
                tagQ.delete();
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] rAddr;
        logic [1:0]  rSize;
        logic [3:0]  cIdx;

        for (int i = 0; i < 64; i++) mem[18'h200 + 18'(i)] = 8'($urandom_range(0, 255));
        mem[18'h100] = 8'h11;
        mem[18'h101] = 8'h22;
        mem[18'h102] = 8'h33;
        mem[18'h103] = 8'h44;
        mem[18'h30000] = 8'h5A;
        mem[18'h30001] = 8'h6B;
        mem[18'h30002] = 8'h7C;
        mem[18'h30003] = 8'h8D;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("rst_resp_data", resp_data, 32'd0);
        checkOutput("rst_replace", {31'd0, cache_replace}, 32'd0);
        checkOutput("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
        checkOutput("rst_ram_addr", ram_addr, 32'd0);

        applyStimulus(1'b0, 2'd2, 32'h100, 32'd0, "cold_word", 1'b1);
        checkOutput("cold_repl", replCount, CACHE_EN ? 32'd1 : 32'd0);
        checkOutput("cold_reads", addrChanges, 32'd4);

        applyStimulus(1'b0, 2'd2, 32'h100, 32'd0, "warm_word", 1'b1);
        checkOutput("warm_reads", addrChanges, CACHE_EN ? 32'd0 : 32'd4);

        applyStimulus(1'b0, 2'd0, 32'h102, 32'd0, "byte_102", 1'b1);
        applyStimulus(1'b0, 2'd1, 32'h102, 32'd0, "half_102", 1'b1);

        applyStimulus(1'b1, 2'd1, 32'h100, 32'h0000BEEF, "st_half", 1'b1);
        checkOutput("st_half_nwr", wrAddrQ.size(), 32'd2);
        for (int i = 0; i < wrAddrQ.size() && i < 2; i++) begin
            checkOutput("st_half_addr", wrAddrQ[i], 32'h100 + 32'(i));
            checkOutput("st_half_byte", {24'd0, wrDataQ[i]}, (i == 0) ? 32'hEF : 32'hBE);
        end
        checkOutput("st_half_repl", replCount, CACHE_EN ? 32'd1 : 32'd0);
        cIdx = 4'h0;
        checkOutput("st_half_cache", cValid[cIdx] ? cData[cIdx] : 32'd0, CACHE_EN ? 32'h4433BEEF : 32'd0);
        applyStimulus(1'b0, 2'd2, 32'h100, 32'd0, "after_st", 1'b1);

        applyStimulus(1'b0, 2'd0, 32'h30000, 32'd0, "io_byte", 1'b1);
        checkOutput("io_byte_reads", addrChanges, 32'd1);
        checkOutput("io_byte_repl", replCount, 32'd0);
        checkOutput("io_byte_addr", ram_addr, 32'h30000);
        applyStimulus(1'b0, 2'd1, 32'h30002, 32'd0, "io_half", 1'b1);
        checkOutput("io_half_reads", addrChanges, 32'd2);
        checkOutput("io_half_repl", replCount, 32'd0);

        applyStimulus(1'b1, 2'd0, 32'h205, 32'h000000C7, "st_byte_miss", 1'b1);
        checkOutput("st_byte_nwr", wrAddrQ.size(), 32'd1);
        checkOutput("st_byte_repl", replCount, 32'd0);
        applyStimulus(1'b1, 2'd2, 32'h208, 32'hA1B2C3D4, "st_word", 1'b1);
        checkOutput("st_word_nwr", wrAddrQ.size(), 32'd4);
        applyStimulus(1'b0, 2'd2, 32'h204, 32'd0, "ld_204", 1'b1);
        applyStimulus(1'b0, 2'd2, 32'h208, 32'd0, "ld_208", 1'b1);

        for (int n = 0; n < 10; n++) begin
            rSize = 2'($urandom_range(0, 2));
            rAddr = 32'h200 + 32'($urandom_range(0, 15) << 2);
            if (rSize == 2'd0) rAddr = rAddr + 32'($urandom_range(0, 3));
            else if (rSize == 2'd1) rAddr = rAddr + 32'($urandom_range(0, 1) << 1);
            applyStimulus(1'b0, rSize, rAddr, 32'd0, "rand_ld", 1'b1);
        end

        // Abort a cold load while byte 2 is being issued.
        applyStimulus(1'b0, 2'd2, 32'h230, 32'd0, "abort", 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("abort_resp", {31'd0, resp_valid}, 32'd0);
        checkOutput("abort_ram_wr", {31'd0, ram_wr}, 32'd0);
        replCount = 0;
        repeat (8) @(negedge clk);
        checkOutput("abort_repl", replCount, 32'd0);
        applyStimulus(1'b0, 2'd2, 32'h230, 32'd0, "post_abort", 1'b1);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
